// File: rtl/mult_share_ctrl.sv
// Shares one 2-stage registered multiplier between NUM_REQ requesters, round-robin, tagging results by id.
// Latency: grant in cycle t, response visible in cycle t+LATENCY+1 (registered show-ahead FIFO output).
// Backpressure: credit-gated issue; grants stop while credits==0, resume the cycle after a response pop.
// Build option: define MULT_SHARE_FIXED_PRIO_EN for fixed lowest-index-wins priority (no RR pointer).
module mult_share_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = 2,
    parameter int RESP_DEPTH = 4,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          mult_enable,
    output logic [DATA_WIDTH-1:0]         mult_a,
    output logic [DATA_WIDTH-1:0]         mult_b,
    input  logic [2*DATA_WIDTH-1:0]       mult_result,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [IDW-1:0]                resp_id,
    output logic [2*DATA_WIDTH-1:0]       resp_result
);

    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int RW = 2 * DATA_WIDTH;

    // Credits stand for free response slots not yet claimed by in-flight or queued results.
    logic [CW-1:0]  credit_q, credit_d;
    logic [IDW-1:0] start_ptr;
    logic [IDW:0]   cand_w;
    logic [IDW-1:0] cand_id;
    logic           issue_ok;
    logic           grant_vld;
    logic [IDW-1:0] grant_id;
    logic           issue;
    logic           pop;
    logic           push;
    logic [IDW-1:0] push_id;

    logic [LATENCY-1:0] fl_vld_q;
    logic [IDW-1:0]     fl_id_q [LATENCY];

    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [IDW-1:0] mem_id [RESP_DEPTH];
    logic [RW-1:0]  mem_res [RESP_DEPTH];
    logic           resp_vld_q, resp_vld_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic [RW-1:0]  resp_res_q, resp_res_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Gating with rst_n keeps grants low for the whole reset assertion, not just after the first edge.
    assign issue_ok = rst_n && (credit_q != '0);

`ifdef MULT_SHARE_FIXED_PRIO_EN
    assign start_ptr = '0;
`else
    logic [IDW-1:0] rr_q, rr_d;

    assign start_ptr = rr_q;

    // Pointer moves past the granted requester only when a handshake actually happens.
    always_comb begin
        rr_d = rr_q;
        if (issue) begin
            rr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Scan requesters from the start pointer; first valid one wins when a credit is available.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand_w    = '0;
        cand_id   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_w = {1'b0, start_ptr} + (IDW + 1)'(i);
            if (cand_w >= (IDW + 1)'(NUM_REQ)) begin
                cand_w = cand_w - (IDW + 1)'(NUM_REQ);
            end
            cand_id = cand_w[IDW-1:0];
            if (!grant_vld && issue_ok && req_valid[cand_id]) begin
                grant_vld = 1'b1;
                grant_id  = cand_id;
            end
        end
    end

    assign issue = grant_vld;

    // One-hot ready and operand mux; operands are zero when nothing is granted.
    always_comb begin
        req_ready = '0;
        mult_a    = '0;
        mult_b    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_vld && (grant_id == IDW'(k))) begin
                req_ready[k] = 1'b1;
                mult_a       = req_a[k*DATA_WIDTH +: DATA_WIDTH];
                mult_b       = req_b[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // In-flight shadow of the multiplier pipeline: {valid,id} per stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fl_vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                fl_id_q[i] <= '0;
            end
        end else begin
            fl_vld_q[0] <= issue;
            fl_id_q[0]  <= grant_id;
            for (int i = 1; i < LATENCY; i++) begin
                fl_vld_q[i] <= fl_vld_q[i-1];
                fl_id_q[i]  <= fl_id_q[i-1];
            end
        end
    end

    assign push        = fl_vld_q[LATENCY-1];
    assign push_id     = fl_id_q[LATENCY-1];
    assign pop         = resp_vld_q && resp_ready;
    assign mult_enable = issue || (|fl_vld_q);

    // Issue claims a credit, pop returns one; both together cancel out.
    always_comb begin
        credit_d = credit_q;
        if (issue && !pop) begin
            credit_d = credit_q - CW'(1);
        end else if (!issue && pop) begin
            credit_d = credit_q + CW'(1);
        end
    end

    // Credit counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= CW'(RESP_DEPTH);
        end else begin
            credit_q <= credit_d;
        end
    end

    // FIFO bookkeeping and next head; a push into an empty (or emptying) queue bypasses storage.
    always_comb begin
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        resp_id_d  = resp_id_q;
        resp_res_d = resp_res_q;
        if (push) begin
            wr_d = ptr_inc(wr_q);
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        resp_vld_d = (count_d != '0);
        if (count_d != '0) begin
            if (push && (rd_d == wr_q)) begin
                resp_id_d  = push_id;
                resp_res_d = mult_result;
            end else begin
                resp_id_d  = mem_id[rd_d];
                resp_res_d = mem_res[rd_d];
            end
        end
    end

    // FIFO pointers, count and registered head outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            resp_vld_q <= 1'b0;
            resp_id_q  <= '0;
            resp_res_q <= '0;
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            resp_vld_q <= resp_vld_d;
            resp_id_q  <= resp_id_d;
            resp_res_q <= resp_res_d;
        end
    end

    // Response storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_q]  <= push_id;
            mem_res[wr_q] <= mult_result;
        end
    end

    assign resp_valid  = resp_vld_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_res_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: behavioural multiplier plus a queue-based reference of grants and responses.
// Latency: responses expected LATENCY+1 cycles after the grant, in grant order.
// Backpressure: resp_ready is held low / randomised to exercise credit exhaustion.
module tb_mult_share_ctrl;

    localparam int DW    = 32;
    localparam int N     = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int IW    = $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_a;
    logic [N*DW-1:0]   req_b;
    logic [N-1:0]      req_ready;
    logic              mult_enable;
    logic [DW-1:0]     mult_a;
    logic [DW-1:0]     mult_b;
    logic [2*DW-1:0]   mult_result;
    logic              resp_valid;
    logic              resp_ready;
    logic [IW-1:0]     resp_id;
    logic [2*DW-1:0]   resp_result;

    mult_share_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (N),
        .LATENCY    (LAT),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .mult_enable (mult_enable),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_result (mult_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result)
    );

    always #5 clk = ~clk;

    // Multiplier: input regs + output reg, enable-gated, cleared while enable is low.
    logic [DW-1:0]   ma_r, mb_r;
    logic [2*DW-1:0] mp_r;
    always @(posedge clk) begin
        if (mult_enable) begin
            ma_r <= mult_a;
            mb_r <= mult_b;
            mp_r <= {{DW{1'b0}}, ma_r} * {{DW{1'b0}}, mb_r};
        end else begin
            ma_r <= '0;
            mb_r <= '0;
            mp_r <= '0;
        end
    end
    assign mult_result = mp_r;

    typedef struct {
        int              id;
        logic [2*DW-1:0] prod;
        int              icyc;
    } ent_t;

    ent_t            q[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc    = 0;
    int              rr     = 0;
    int              hs_cnt = 0;
    int              gnt_log[$];
    logic [IW-1:0]   last_id  = '0;
    logic [2*DW-1:0] last_res = '0;

    logic            s_hs, s_pop, s_rv;
    int              s_id;
    logic [DW-1:0]   s_a, s_b;
    logic [IW-1:0]   s_rid;
    logic [2*DW-1:0] s_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare DUT outputs with what the rules predict for the current inputs and history.
    task automatic check_cycle();
        logic [N-1:0]  exp_rdy;
        logic [DW-1:0] exp_a, exp_b;
        logic          exp_en, exp_rv;
        int            exp_id, start, k;
        exp_rdy = '0;
        exp_a   = '0;
        exp_b   = '0;
        exp_id  = -1;
`ifdef MULT_SHARE_FIXED_PRIO_EN
        start = 0;
`else
        start = rr;
`endif
        if (q.size() < DEPTH) begin
            for (int i = 0; i < N; i++) begin
                k = (start + i) % N;
                if (exp_id < 0 && req_valid[k]) exp_id = k;
            end
        end
        if (exp_id >= 0) begin
            exp_rdy[exp_id] = 1'b1;
            exp_a = req_a[exp_id*DW +: DW];
            exp_b = req_b[exp_id*DW +: DW];
        end
        exp_en = (exp_id >= 0);
        foreach (q[j]) if (q[j].icyc >= cyc - LAT && q[j].icyc < cyc) exp_en = 1'b1;
        exp_rv = (q.size() > 0) && (q[0].icyc + LAT + 1 <= cyc);

        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("mult_a", 64'(mult_a), 64'(exp_a));
        chk("mult_b", 64'(mult_b), 64'(exp_b));
        chk("mult_enable", 64'(mult_enable), 64'(exp_en));
        chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
        if (exp_rv) begin
            chk("resp_id", 64'(resp_id), 64'(q[0].id));
            chk("resp_result", resp_result, q[0].prod);
        end else begin
            chk("resp_id_hold", 64'(resp_id), 64'(last_id));
            chk("resp_result_hold", resp_result, last_res);
        end

        s_hs  = |(req_valid & req_ready);
        s_id  = 0;
        for (int i = N - 1; i >= 0; i--) if (req_ready[i]) s_id = i;
        s_a   = req_a[s_id*DW +: DW];
        s_b   = req_b[s_id*DW +: DW];
        s_pop = resp_valid && resp_ready;
        s_rv  = resp_valid;
        s_rid = resp_id;
        s_res = resp_result;
    endtask

    task automatic update_model();
        ent_t e;
        if (s_pop && q.size() > 0) begin
            last_id  = IW'(q[0].id);
            last_res = q[0].prod;
            void'(q.pop_front());
        end
        if (s_hs) begin
            e.id   = s_id;
            e.prod = {{DW{1'b0}}, s_a} * {{DW{1'b0}}, s_b};
            e.icyc = cyc;
            q.push_back(e);
            hs_cnt++;
            gnt_log.push_back(s_id);
            rr = (s_id + 1) % N;
        end
        chk("occupancy_le_depth", 64'(q.size() <= DEPTH), 64'd1);
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        update_model();
        cyc++;
        #1;
    endtask

    task automatic set_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_valid[k] = 1'b1;
        req_a[k*DW +: DW] = a;
        req_b[k*DW +: DW] = b;
    endtask

    task automatic all_random(input logic [N-1:0] vmask);
        req_valid = '0;
        for (int k = 0; k < N; k++) if (vmask[k]) set_req(k, $urandom, $urandom);
    endtask

    task automatic drain();
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH + LAT + 2 && q.size() > 0; i++) step();
        step();
        chk("drained", 64'(q.size()), 64'd0);
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_mult_enable"}, 64'(mult_enable), 64'd0);
        chk({tag, "_mult_a"}, 64'(mult_a), 64'd0);
        chk({tag, "_mult_b"}, 64'(mult_b), 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_id"}, 64'(resp_id), 64'd0);
        chk({tag, "_resp_result"}, resp_result, 64'd0);
    endtask

    task automatic single_op(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [63:0] exp_prod, input string tag);
        int lat;
        req_valid  = '0;
        resp_ready = 1'b1;
        set_req(k, a, b);
        step();
        chk({tag, "_granted"}, 64'(s_hs && s_id == k), 64'd1);
        req_valid = '0;
        lat = 0;
        s_rv = 1'b0;
        for (int i = 0; i < 8 && !s_rv; i++) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(LAT + 1));
        chk({tag, "_id"}, 64'(s_rid), 64'(k));
        chk({tag, "_product"}, s_res, exp_prod);
        drain();
    endtask

    initial begin
        int exp_seq[5];
        rst_n      = 1'b0;
        resp_ready = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        all_random('1);

        // Reset state with requests pending.
        #12;
        reset_outputs_zero("reset");
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All four requesters continuously valid, consumer always ready.
        resp_ready = 1'b1;
        gnt_log.delete();
        for (int i = 0; i < 12; i++) begin
            all_random('1);
            step();
        end
`ifdef MULT_SHARE_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 5; i++) chk("grant_seq", 64'(gnt_log[i]), 64'(exp_seq[i]));
        drain();

        // Single op and max operands.
        single_op(2, 32'h0000_0007, 32'h0000_0003, 64'd21, "single");
        single_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "maxop");

        // Backpressure: credits run out after DEPTH handshakes.
        resp_ready = 1'b0;
        hs_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            all_random('1);
            step();
        end
        chk("bp_handshakes", 64'(hs_cnt), 64'(DEPTH));
        resp_ready = 1'b1;
        all_random('1);
        step();
        chk("bp_pop_cycle_no_grant", 64'(s_hs), 64'd0);
        chk("bp_pop_cycle_pops", 64'(s_pop), 64'd1);
        all_random('1);
        step();
        chk("bp_grant_resumes", 64'(s_hs), 64'd1);
        for (int i = 0; i < 6; i++) begin
            all_random('1);
            step();
        end
        drain();

        // Randomised traffic with random consumer stalls.
        for (int i = 0; i < 400; i++) begin
            all_random(N'($urandom));
            resp_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        // Reset while two ops are in flight and one is queued.
        resp_ready = 1'b0;
        req_valid  = '0;
        set_req(0, $urandom, $urandom);
        step();
        req_valid = '0;
        for (int i = 0; i < LAT + 1; i++) step();
        chk("pre_reset_queued", 64'(s_rv), 64'd1);
        all_random(4'b0011);
        step();
        all_random(4'b0011);
        step();
        rst_n = 1'b0;
        #2;
        reset_outputs_zero("midreset");
        q.delete();
        rr       = 0;
        last_id  = '0;
        last_res = '0;
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        single_op(3, 32'h0001_2345, 32'h0000_0100, 64'h0000_0000_0123_4500, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Time-shares one registered multiplier (input regs + output reg, `enable`-gated, 2-cycle latency) between NUM_REQ requesters.
- Round-robin arbitration on a valid/ready request side; tags each issued operation with its requester id.
- Since the multiplier cannot stall (enable low clears its registers), issue is credit-gated against a response FIFO, so no result is ever dropped.
- Sits between the requesting engines and the multiplier instance.

Parameters:
- DATA_WIDTH, 32, operand width; results are 2*DATA_WIDTH.
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 2, cycles from operands driven on mult_a/mult_b to a valid mult_result.
- RESP_DEPTH, 4, response FIFO entries; must be >= LATENCY+1.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_a  in  NUM_REQ*DATA_WIDTH  operand A; slice k belongs to requester k.
- req_b  in  NUM_REQ*DATA_WIDTH  operand B, same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant; the request is accepted when valid&ready.
- mult_enable  out  1  drives the multiplier `enable`.
- mult_a  out  DATA_WIDTH  operand A to the multiplier.
- mult_b  out  DATA_WIDTH  operand B to the multiplier.
- mult_result  in  2*DATA_WIDTH  multiplier output.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  clog2(NUM_REQ)  requester id of the response.
- resp_result  out  2*DATA_WIDTH  product.

Behaviour:
- Reset (async assert, sync release):
  - req_ready=0, mult_enable=0, mult_a=mult_b=0, resp_valid=0, resp_id=0, resp_result=0.
  - RR pointer=0, in-flight shift register cleared, FIFO empty, credits=RESP_DEPTH.
- Credits:
  - credits = RESP_DEPTH − fifo_count − inflight_count.
  - Issue is allowed only when credits>0.
  - Issue and pop in the same cycle: the counter nets to zero change.
- Arbitration (combinational, each cycle):
  - Search starts at the RR pointer; the first requester with req_valid set and issue allowed gets req_ready.
  - At most one bit of req_ready is set.
  - No request pending, or credits==0: req_ready=0.
- Issue, cycle t:
  - Granted operands are driven on mult_a/mult_b in cycle t; otherwise mult_a/mult_b are 0.
  - RR pointer is updated to grant+1 (mod NUM_REQ) only on a handshake.
- In-flight tracking:
  - A LATENCY-stage shift register of {valid,id}.
  - Stage 0 loads at the edge ending cycle t.
  - The last stage is valid in cycle t+LATENCY, coinciding with mult_result.
  - In that cycle, {id, mult_result} is pushed into the FIFO at the end-of-cycle edge.
  - resp_valid is therefore earliest in cycle t+LATENCY+1.
- mult_enable:
  - High in any cycle with an issue or any valid in-flight stage; low otherwise.
  - The multiplier registers clearing while idle is harmless.
- Response FIFO:
  - Registered outputs; show-ahead; pops on resp_valid&resp_ready.
  - Push while full cannot occur by construction; the bench asserts this.
  - Empty: resp_valid=0, and resp_id/resp_result hold their last value.
  - Simultaneous push and pop on a full FIFO is legal.
- Throughput:
  - One issue per cycle while resp_ready stays high.
  - Order of responses equals issue order.
- Reset mid-operation:
  - In-flight and queued results are discarded.
  - No response is generated after release.

Optional Feature:
- MULT_SHARE_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins; the RR pointer is not implemented.
  - Undefined: round-robin as above.

Test Plan:
- Single op, NUM_REQ=4: req 2 sends a=0x0000_0007, b=0x0000_0003 in cycle 1.
  - req_ready[2]=1 in cycle 1.
  - resp_valid=1 in cycle 4 with resp_id=2, resp_result=21.
- All 4 requesters valid continuously, resp_ready=1:
  - Grants go 0,1,2,3,0 in consecutive cycles.
  - Responses arrive in the same id order, one per cycle.
- Backpressure, RESP_DEPTH=4: resp_ready=0 with continuous requests.
  - Exactly 4 handshakes occur, then req_ready=0.
  - When resp_ready rises, grants resume one cycle after the first pop, and no result is lost.
- Max operands: a=b=0xFFFF_FFFF.
  - resp_result=0xFFFF_FFFE_0000_0001.
- rst_n pulsed low while 2 ops are in flight and 1 is queued:
  - All outputs return to 0 immediately.
  - No resp_valid after release; the next op completes normally.
- With MULT_SHARE_FIXED_PRIO_EN defined, req 0 and req 3 held valid:
  - req 0 is granted every cycle; req 3 is never granted until req 0 drops.
